// File: rtl/pipelined_data_memory.sv
// Shared data/fetch memory with a one-deep store buffer, read forwarding,
// optional clear-after-reset sequencing and saturating access counters.
module pipelined_data_memory #(
   parameter int    AW             = 8,
   parameter int    DW             = 8,
   parameter bit    CLEAR_ON_RESET = 1'b0,
   parameter string INIT_FILE      = "data.mif"
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          MemRead,
   input  logic          wren,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] q,
   input  logic [AW-1:0] address_pc,
   output logic [DW-1:0] q_pc,
   output logic          ready,
   output logic [15:0]   rd_count,
   output logic [15:0]   wr_count
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t        state;
   logic [AW-1:0] clr_addr;

   logic          pend_valid;
   logic [AW-1:0] pend_addr;
   logic [DW-1:0] pend_data;

   (* ram_init_file = INIT_FILE *)
   logic [DW-1:0] mem [DEPTH];

   logic          run;
   logic [DW-1:0] rd_sel;
   logic [DW-1:0] pc_sel;

   assign run = (state == RUN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= CLEAR_ON_RESET ? INIT : RUN;
         ready    <= !CLEAR_ON_RESET;
         clr_addr <= '0;
      end else begin
         unique case (state)
            INIT: begin
               clr_addr <= clr_addr + 1'b1;
               if (&clr_addr) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               ready <= 1'b1;
            end
            default: begin
               state <= RUN;
               ready <= 1'b1;
            end
         endcase
      end
   end

   // Single array write port: clearing during INIT, buffered commits after.
   always_ff @(posedge clock) begin
      if (state == INIT) begin
         mem[clr_addr] <= '0;
      end else if (pend_valid) begin
         mem[pend_addr] <= pend_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
      end else if (run) begin
         pend_valid <= wren;
         if (wren) begin
            pend_addr <= address;
            pend_data <= data;
         end
      end
   end

   // The data-port write always targets the data-port read address.
   always_comb begin
      rd_sel = mem[address];
      if (wren) begin
         rd_sel = data;
      end else if (pend_valid && (pend_addr == address)) begin
         rd_sel = pend_data;
      end
   end

   always_comb begin
      pc_sel = mem[address_pc];
      if (wren && (address == address_pc)) begin
         pc_sel = data;
      end else if (pend_valid && (pend_addr == address_pc)) begin
         pc_sel = pend_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q    <= '0;
         q_pc <= '0;
      end else if (run) begin
         if (MemRead) begin
            q <= rd_sel;
         end
         q_pc <= pc_sel;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (run) begin
         if (MemRead && (rd_count != 16'hFFFF)) begin
            rd_count <= rd_count + 16'd1;
         end
         if (wren && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Bench for pipelined_data_memory: vector table through a queued
// scoreboard, plus reset, clear-sequencing and saturation sequences.
module tb_pipelined_data_memory;

   logic       clock;
   logic       reset;
   logic       MemRead;
   logic       wren;
   logic [7:0] address;
   logic [7:0] data;
   logic [7:0] address_pc;

   logic [7:0]  q_c, qpc_c, q_n, qpc_n;
   logic        ready_c, ready_n;
   logic [15:0] rdc_c, wrc_c, rdc_n, wrc_n;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          id;
      logic        rd;
      logic        wr;
      logic [7:0]  addr;
      logic [7:0]  dat;
      logic [7:0]  pc;
      logic        chk_q;
      logic [7:0]  eq;
      logic [7:0]  epc;
      logic [15:0] erd;
      logic [15:0] ewr;
   } vec_t;

   vec_t tbl [15];
   vec_t sb [$];
   vec_t mon_e;

   pipelined_data_memory #(
      .AW(8), .DW(8), .CLEAR_ON_RESET(1'b1), .INIT_FILE("data.mif")
   ) u_clr (
      .clock(clock), .reset(reset), .MemRead(MemRead), .wren(wren),
      .address(address), .data(data), .q(q_c),
      .address_pc(address_pc), .q_pc(qpc_c), .ready(ready_c),
      .rd_count(rdc_c), .wr_count(wrc_c)
   );

   pipelined_data_memory #(
      .AW(8), .DW(8), .CLEAR_ON_RESET(1'b0), .INIT_FILE("data.mif")
   ) u_noclr (
      .clock(clock), .reset(reset), .MemRead(MemRead), .wren(wren),
      .address(address), .data(data), .q(q_n),
      .address_pc(address_pc), .q_pc(qpc_n), .ready(ready_n),
      .rd_count(rdc_n), .wr_count(wrc_n)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int id, input logic rd,
         input logic wr, input logic [7:0] addr, input logic [7:0] dat,
         input logic [7:0] pc, input logic chk_q, input logic [7:0] eq,
         input logic [7:0] epc, input logic [15:0] erd,
         input logic [15:0] ewr);
      vec_t v;
      v.id = id; v.rd = rd; v.wr = wr; v.addr = addr; v.dat = dat;
      v.pc = pc; v.chk_q = chk_q; v.eq = eq; v.epc = epc;
      v.erd = erd; v.ewr = ewr;
      return v;
   endfunction

   always @(posedge clock) begin
      #1;
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         if (mon_e.chk_q)
            chk($sformatf("row%0d q", mon_e.id), q_c, mon_e.eq);
         chk($sformatf("row%0d q_pc", mon_e.id), qpc_c, mon_e.epc);
         chk($sformatf("row%0d rd_count", mon_e.id), rdc_c, mon_e.erd);
         chk($sformatf("row%0d wr_count", mon_e.id), wrc_c, mon_e.ewr);
      end
   end

   // Runs from reset release until u_clr raises ready, pulsing requests.
   task automatic wait_init(output int n);
      logic ok;
      n = 0;
      ok = 1'b0;
      do begin
         MemRead    = (n % 7) == 3;
         wren       = (n % 5) == 1;
         address    = 8'h00;
         data       = 8'hA5;
         address_pc = 8'h00;
         @(posedge clock);
         #1;
         n++;
         ok = ready_c;
         @(negedge clock);
      end while (!ok && n < 1000);
      MemRead = 1'b0;
      wren    = 1'b0;
   endtask

   initial begin
      int n;
      tbl[0]  = mk(0,  1, 0, 8'h00, 8'h00, 8'h01, 1, 8'h00, 8'h00, 1, 0);
      tbl[1]  = mk(1,  1, 0, 8'h7F, 8'h00, 8'h80, 1, 8'h00, 8'h00, 2, 0);
      tbl[2]  = mk(2,  1, 0, 8'hFF, 8'h00, 8'hFE, 1, 8'h00, 8'h00, 3, 0);
      tbl[3]  = mk(3,  0, 1, 8'h10, 8'h5A, 8'h10, 1, 8'h00, 8'h5A, 3, 1);
      tbl[4]  = mk(4,  1, 0, 8'h10, 8'h00, 8'h10, 1, 8'h5A, 8'h5A, 4, 1);
      tbl[5]  = mk(5,  0, 0, 8'h10, 8'h00, 8'h10, 1, 8'h5A, 8'h5A, 4, 1);
      tbl[6]  = mk(6,  1, 0, 8'h10, 8'h00, 8'h7F, 1, 8'h5A, 8'h00, 5, 1);
      tbl[7]  = mk(7,  1, 1, 8'h20, 8'hC3, 8'h20, 1, 8'hC3, 8'hC3, 6, 2);
      tbl[8]  = mk(8,  0, 1, 8'h30, 8'h11, 8'h30, 0, 8'h00, 8'h11, 6, 3);
      tbl[9]  = mk(9,  0, 1, 8'h31, 8'h22, 8'h30, 0, 8'h00, 8'h11, 6, 4);
      tbl[10] = mk(10, 0, 1, 8'h30, 8'h33, 8'h31, 0, 8'h00, 8'h22, 6, 5);
      tbl[11] = mk(11, 1, 0, 8'h30, 8'h00, 8'h31, 1, 8'h33, 8'h22, 7, 5);
      tbl[12] = mk(12, 1, 0, 8'h31, 8'h00, 8'h20, 1, 8'h22, 8'hC3, 8, 5);
      tbl[13] = mk(13, 1, 0, 8'h30, 8'h00, 8'h10, 1, 8'h33, 8'h5A, 9, 5);
      tbl[14] = mk(14, 0, 0, 8'h10, 8'h00, 8'h7F, 1, 8'h33, 8'h00, 9, 5);

      reset = 1'b1;
      MemRead = 1'b0;
      wren = 1'b0;
      address = 8'h00;
      data = 8'h00;
      address_pc = 8'h00;

      @(posedge clock);
      #1;
      chk("reset q", q_c, 0);
      chk("reset q_pc", qpc_c, 0);
      chk("reset ready clr", ready_c, 0);
      chk("reset ready noclr", ready_n, 1);
      chk("reset rd_count", rdc_c, 0);
      chk("reset wr_count", wrc_c, 0);

      @(negedge clock);
      reset = 1'b0;
      wait_init(n);
      chk("init length", n, 256);
      chk("init q", q_c, 0);
      chk("init q_pc", qpc_c, 0);
      chk("init rd_count", rdc_c, 0);
      chk("init wr_count", wrc_c, 0);

      for (int i = 0; i < 15; i++) begin
         MemRead    = tbl[i].rd;
         wren       = tbl[i].wr;
         address    = tbl[i].addr;
         data       = tbl[i].dat;
         address_pc = tbl[i].pc;
         sb.push_back(tbl[i]);
         @(negedge clock);
      end
      MemRead = 1'b0;
      chk("scoreboard drained", sb.size(), 0);

      wren = 1'b1; address = 8'h40; data = 8'h77;
      @(negedge clock);
      wren = 1'b0;
      @(negedge clock);
      wren = 1'b1; data = 8'hEE;
      @(negedge clock);
      wren = 1'b0;
      reset = 1'b1;
      #1;
      chk("midreset q noclr", q_n, 0);
      chk("midreset q_pc noclr", qpc_n, 0);
      chk("midreset wr_count", wrc_c, 0);
      chk("midreset rd_count noclr", rdc_n, 0);
      chk("midreset ready", ready_c, 0);
      @(negedge clock);
      reset = 1'b0;
      wait_init(n);
      chk("reinit length", n, 256);

      MemRead = 1'b1; address = 8'h40; address_pc = 8'h40;
      @(posedge clock);
      #1;
      chk("discard q noclr", q_n, 8'h77);
      chk("discard q_pc noclr", qpc_n, 8'h77);
      chk("cleared q", q_c, 0);
      chk("cleared q_pc", qpc_c, 0);
      chk("post rd_count", rdc_c, 1);

      @(negedge clock);
      address = 8'h00;
      repeat (65533) @(posedge clock);
      #1;
      chk("rd_count near sat", rdc_c, 16'hFFFE);
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("rd_count sat%0d", k), rdc_c, 16'hFFFF);
      end
      @(negedge clock);
      MemRead = 1'b0;
      chk("wr_count idle", wrc_c, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
